// File: rtl/atm_pkg.sv
// Shared definitions for the ATM vault arbiter and the session controller:
// FSM state encoding, amount and operation codes, note-count helper.
package atm_pkg;

    localparam int NUM_REQ = 2;
    localparam int NOTE_W  = 8;
    localparam int CNT_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_CHECK = 3'd2,
        ST_XFER  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        AMT_INVALID = 2'b00,
        FIFTY       = 2'b01,
        HUNDRED     = 2'b10,
        TWO_HUNDRED = 2'b11
    } amt_e;

    typedef enum logic {
        OP_DEPOSIT  = 1'b0,
        OP_WITHDRAW = 1'b1
    } op_e;

    // Number of 50000 notes moved for an amount code (0 for the invalid code).
    function automatic logic [CNT_W-1:0] amt_notes(input amt_e code);
        case (code)
            FIFTY:       return 3'd1;
            HUNDRED:     return 3'd2;
            TWO_HUNDRED: return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/atm_vault_arbiter_if.sv
// Terminal-side bundle of the vault arbiter: per-requester request fields
// plus grant/completion/note-transfer status back to the terminals.
interface atm_vault_arbiter_if;
    logic [1:0] req;
    logic [1:0] op;
    logic [3:0] amt;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [1:0] deny;
    logic       note_pulse;
    logic       note_dir;
    logic [7:0] balance;
    logic       busy;

    // Terminal side drives the requests.
    modport master (
        output req, op, amt,
        input  gnt, done, deny, note_pulse, note_dir, balance, busy
    );

    // Vault side answers them.
    modport slave (
        input  req, op, amt,
        output gnt, done, deny, note_pulse, note_dir, balance, busy
    );
endinterface

// File: rtl/atm_rr_arbiter.sv
// Two-way round-robin pick; the pointer remembers who was served last and
// only moves when a transaction is retired.
module atm_rr_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served_idx,
    output logic       pick
);
    logic last_q;
    logic last_d;

    // Pointer follows the requester just retired.
    always_comb begin
        last_d = last_q;
        if (update) begin
            last_d = served_idx;
        end
    end

    // Single requester wins outright; on a tie the one not served last wins.
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_q;
            default: pick = 1'b0;
        endcase
    end

    // After reset A counts as last served, so B takes the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/atm_vault_arbiter.sv
// Vault arbiter: grants one of two terminals, validates the request against
// the vault balance and moves notes one per cycle.
module atm_vault_arbiter
    import atm_pkg::*;
#(
    parameter logic [7:0] INIT_NOTES = 8'd20,
    parameter logic [7:0] MAX_NOTES  = 8'd255
) (
    input  logic                clock,
    input  logic                reset,
    atm_vault_arbiter_if.slave  bus
);
    state_e              state_q, state_d;
    logic                idx_q, idx_d;
    op_e                 op_q, op_d;
    amt_e                amt_q, amt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ok_q, ok_d;
    logic [NOTE_W-1:0]   bal_q, bal_d;

    logic                pick;
    logic                retire;
    logic                reject;
    logic [CNT_W-1:0]    notes;
    logic [NUM_REQ-1:0]  gnt_vec, done_vec, deny_vec;

    atm_rr_arbiter u_rr (
        .clock      (clock),
        .reset      (reset),
        .req        (bus.req),
        .update     (retire),
        .served_idx (idx_q),
        .pick       (pick)
    );

    // Reject invalid codes, overdrafts and deposits that would overflow capacity.
    always_comb begin
        notes  = amt_notes(amt_q);
        reject = 1'b0;
        if (amt_q == AMT_INVALID) begin
            reject = 1'b1;
        end else if (op_q == OP_WITHDRAW) begin
            reject = ({{(NOTE_W-CNT_W){1'b0}}, notes} > bal_q);
        end else begin
            reject = ({1'b0, bal_q} + {{(NOTE_W+1-CNT_W){1'b0}}, notes}) > {1'b0, MAX_NOTES};
        end
    end

    // Next-state and datapath updates for the transaction sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        amt_d   = amt_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
        bal_d   = bal_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    idx_d   = pick;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Request fields are frozen here; later input changes are ignored.
                op_d    = op_e'(bus.op[idx_q]);
                amt_d   = amt_e'(idx_q ? bus.amt[3:2] : bus.amt[1:0]);
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (reject) begin
                    ok_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    ok_d    = 1'b1;
                    cnt_d   = notes;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                bal_d = (op_q == OP_WITHDRAW) ? bal_q - 8'd1 : bal_q + 8'd1;
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                retire  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 1'b0;
            op_q    <= OP_DEPOSIT;
            amt_q   <= AMT_INVALID;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            bal_q   <= INIT_NOTES;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            bal_q   <= bal_d;
        end
    end

    // Per-requester grant and completion pulses decoded from state.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign gnt_vec[gi]  = (state_q != ST_IDLE) && (idx_q == 1'(gi));
        assign done_vec[gi] = (state_q == ST_DONE) && ok_q  && (idx_q == 1'(gi));
        assign deny_vec[gi] = (state_q == ST_DONE) && !ok_q && (idx_q == 1'(gi));
    end

    assign bus.gnt        = gnt_vec;
    assign bus.done       = done_vec;
    assign bus.deny       = deny_vec;
    assign bus.note_pulse = (state_q == ST_XFER);
    assign bus.note_dir   = (state_q == ST_XFER) && (op_q == OP_WITHDRAW);
    assign bus.balance    = bal_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_atm_vault_arbiter.sv
// Self-checking bench for atm_vault_arbiter: directed boundary cases plus
// randomized transactions compared against a transaction-level vault model.
module tb_atm_vault_arbiter;
    localparam int MAX_N  = 255;
    localparam int INIT_N = 20;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   txn_no;

    // Reference model state: vault notes and last served terminal.
    int   m_bal;
    logic m_last;

    atm_vault_arbiter_if bus ();

    atm_vault_arbiter #(
        .INIT_NOTES (8'd20),
        .MAX_NOTES  (8'd255)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int notes_of(input logic [1:0] code);
        case (code)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 2'b00;
        bus.op  = 2'b00;
        bus.amt = 4'b0000;
        next_cycle();
        @(negedge clk);
        check_eq("rst_gnt",   32'(bus.gnt), 32'd0);
        check_eq("rst_done",  32'(bus.done), 32'd0);
        check_eq("rst_deny",  32'(bus.deny), 32'd0);
        check_eq("rst_pulse", 32'(bus.note_pulse), 32'd0);
        check_eq("rst_dir",   32'(bus.note_dir), 32'd0);
        check_eq("rst_busy",  32'(bus.busy), 32'd0);
        check_eq("rst_bal",   32'(bus.balance), 32'(INIT_N));
        next_cycle();
        rst = 1'b0;
        m_bal  = INIT_N;
        m_last = 1'b0;
    endtask

    // Quiet cycles: vault idle, balance untouched.
    task automatic idle_cycles(input int k);
        bus.req = 2'b00;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check_eq("idle_busy", 32'(bus.busy), 32'd0);
            check_eq("idle_gnt",  32'(bus.gnt), 32'd0);
            check_eq("idle_dd",   32'({bus.done, bus.deny, bus.note_pulse}), 32'd0);
            check_eq("idle_bal",  32'(bus.balance), 32'(m_bal));
            next_cycle();
        end
    endtask

    // One transaction, starting in an IDLE cycle. Expectations come from the
    // arbitration and vault rules: winner, note count, accept/deny, timeline.
    task automatic run_txn(input logic [1:0] r, input logic [1:0] o, input logic [3:0] a,
                           input bit scramble);
        logic       w;
        int         wi;
        logic       wop;
        logic [1:0] wamt;
        int         n;
        bit         rej;
        logic [1:0] oh;
        int         bal0;

        bus.req = r;
        bus.op  = o;
        bus.amt = a;
        if (r == 2'b01)      w = 1'b0;
        else if (r == 2'b10) w = 1'b1;
        else                 w = ~m_last;
        wi   = int'(w);
        wop  = o[wi];
        wamt = a[2*wi +: 2];
        n    = notes_of(wamt);
        bal0 = m_bal;
        if (n == 0)        rej = 1'b1;
        else if (wop)      rej = (n > m_bal);
        else               rej = (m_bal + n > MAX_N);
        oh = (w == 1'b0) ? 2'b01 : 2'b10;

        // IDLE cycle (latency cycle 0)
        @(negedge clk);
        check_eq("t0_busy", 32'(bus.busy), 32'd0);
        check_eq("t0_gnt",  32'(bus.gnt), 32'd0);
        check_eq("t0_dd",   32'({bus.done, bus.deny}), 32'd0);

        // GRANT (cycle 1): op/amt still presented
        next_cycle();
        if (scramble) bus.req = 2'($urandom);
        @(negedge clk);
        check_eq("grant_gnt",  32'(bus.gnt), 32'(oh));
        check_eq("grant_busy", 32'(bus.busy), 32'd1);
        check_eq("grant_dd",   32'({bus.done, bus.deny, bus.note_pulse}), 32'd0);

        // CHECK (cycle 2): inputs may change freely now
        next_cycle();
        if (scramble) begin
            bus.req = 2'($urandom);
            bus.op  = 2'($urandom);
            bus.amt = 4'($urandom);
        end
        @(negedge clk);
        check_eq("check_gnt",   32'(bus.gnt), 32'(oh));
        check_eq("check_pulse", 32'(bus.note_pulse), 32'd0);
        check_eq("check_bal",   32'(bus.balance), 32'(bal0));

        if (rej) begin
            next_cycle();
            @(negedge clk);
            check_eq("deny_pulse", 32'(bus.deny), 32'(oh));
            check_eq("deny_done",  32'(bus.done), 32'd0);
            check_eq("deny_notes", 32'(bus.note_pulse), 32'd0);
            check_eq("deny_bal",   32'(bus.balance), 32'(bal0));
            check_eq("deny_gnt",   32'(bus.gnt), 32'(oh));
        end else begin
            for (int i = 0; i < n; i++) begin
                next_cycle();
                if (scramble) bus.op = 2'($urandom);
                @(negedge clk);
                check_eq("xfer_pulse", 32'(bus.note_pulse), 32'd1);
                check_eq("xfer_dir",   32'(bus.note_dir), 32'(wop));
                check_eq("xfer_dd",    32'({bus.done, bus.deny}), 32'd0);
                check_eq("xfer_gnt",   32'(bus.gnt), 32'(oh));
            end
            m_bal = wop ? m_bal - n : m_bal + n;
            next_cycle();
            @(negedge clk);
            check_eq("done_pulse", 32'(bus.done), 32'(oh));
            check_eq("done_deny",  32'(bus.deny), 32'd0);
            check_eq("done_notes", 32'(bus.note_pulse), 32'd0);
            check_eq("done_bal",   32'(bus.balance), 32'(m_bal));
            check_eq("done_gnt",   32'(bus.gnt), 32'(oh));
        end
        m_last = w;
        txn_no++;
        $display("txn %0d req=%b op=%b amt=%b winner=%s notes=%0d result=%s bal %0d->%0d",
                 txn_no, r, o, a, w ? "B" : "A", n, rej ? "deny" : "done", bal0, m_bal);
        next_cycle();
        bus.req = 2'b00;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        txn_no   = 0;
        m_bal    = INIT_N;
        m_last   = 1'b0;
        rst      = 1'b1;
        bus.req  = 2'b00;
        bus.op   = 2'b00;
        bus.amt  = 4'b0000;
        repeat (2) @(posedge clk);
        #1;

        // A withdraws 100000: two dispensed notes, done at cycle 5
        do_reset();
        run_txn(2'b01, 2'b01, 4'b0010, 1'b0);

        // Both hold req from reset, both withdraw 50000: B then A
        do_reset();
        run_txn(2'b11, 2'b11, 4'b0101, 1'b0);
        run_txn(2'b11, 2'b11, 4'b0101, 1'b0);
        idle_cycles(2);

        // Drain 18 -> 3, then a 200000 withdraw must be denied
        for (int i = 0; i < 3; i++) run_txn(2'b01, 2'b01, 4'b0011, 1'b1);
        run_txn(2'b10, 2'b10, 4'b1000, 1'b1);
        run_txn(2'b10, 2'b10, 4'b0100, 1'b1);
        run_txn(2'b01, 2'b01, 4'b0011, 1'b1);

        // Fill 3 -> 253, then capacity edge cases
        for (int i = 0; i < 62; i++) run_txn(2'b01, 2'b00, 4'b0011, 1'b1);
        run_txn(2'b10, 2'b00, 4'b1000, 1'b1);
        run_txn(2'b01, 2'b00, 4'b0011, 1'b1);
        run_txn(2'b10, 2'b00, 4'b1000, 1'b1);
        run_txn(2'b01, 2'b00, 4'b0001, 1'b1);
        run_txn(2'b10, 2'b11, 4'b0011, 1'b1);

        // Reset in the middle of a transfer: no completion, vault reloaded
        bus.req = 2'b01;
        bus.op  = 2'b01;
        bus.amt = 4'b0011;
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("abort_inxfer", 32'(bus.note_pulse), 32'd1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        bus.req = 2'b00;
        m_bal  = INIT_N;
        m_last = 1'b0;
        idle_cycles(3);

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            run_txn(2'($urandom_range(1, 3)), 2'($urandom), 4'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
